// File: rtl/exe_stage_mc.sv
// LA32R execute stage: one-hot ALU, N-source operand forwarding, EXE->MEM register.
// Define EXE_DIV_EN to build in the 34-cycle iterative divider; otherwise divides return 0 in one cycle.
module exe_stage_mc #(
  parameter int unsigned NUM_FWD  = 2,
  parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ds_to_es_valid,
  output logic                   es_allow_in,
  input  logic                   flush,
  input  logic                   stall,
  input  logic [31:0]            ds_pc,
  input  logic [11:0]            alu_op,
  input  logic [3:0]             div_op,
  input  logic [31:0]            src1,
  input  logic [31:0]            src2,
  input  logic [4:0]             raddr1,
  input  logic [4:0]             raddr2,
  input  logic                   mem_en,
  input  logic [3:0]             mem_we,
  input  logic [3:0]             rf_we,
  input  logic [4:0]             rf_waddr,
  input  logic [NUM_FWD-1:0]     fwd_we,
  input  logic [5*NUM_FWD-1:0]   fwd_waddr,
  input  logic [32*NUM_FWD-1:0]  fwd_wdata,
  input  logic                   ms_allow_in,
  output logic                   es_to_ms_valid,
  output logic [4:0]             es_rf_waddr_o,
  output logic                   es_busy,
  output logic                   ms_valid,
  output logic [31:0]            ms_pc,
  output logic [31:0]            ms_addr,
  output logic [31:0]            ms_wdata,
  output logic [31:0]            ms_rf_wdata,
  output logic                   ms_mem_en,
  output logic [3:0]             ms_mem_we,
  output logic [3:0]             ms_rf_we,
  output logic [4:0]             ms_rf_waddr
);

  // Scan from the oldest source down so the lowest index overrides.
  function automatic logic [31:0] fwd_pick(input logic [4:0] raddr, input logic [31:0] raw,
                                           input logic [NUM_FWD-1:0] we,
                                           input logic [5*NUM_FWD-1:0] wa,
                                           input logic [32*NUM_FWD-1:0] wd);
    logic [31:0] r;
    r = raw;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (we[i] && (wa[5*i +: 5] != 5'd0) && (wa[5*i +: 5] == raddr)) r = wd[32*i +: 32];
    end
    return r;
  endfunction

  function automatic logic [31:0] alu_calc(input logic [11:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0]        r;
    logic signed [31:0] sa;
    sa = $signed(a) >>> b[4:0];
    r  = '0;
    if (op[0])  r = r | (a + b);
    if (op[1])  r = r | (a - b);
    if (op[2])  r = r | {31'd0, ($signed(a) < $signed(b))};
    if (op[3])  r = r | {31'd0, (a < b)};
    if (op[4])  r = r | (a & b);
    if (op[5])  r = r | ~(a | b);
    if (op[6])  r = r | (a | b);
    if (op[7])  r = r | (a ^ b);
    if (op[8])  r = r | (a << b[4:0]);
    if (op[9])  r = r | (a >> b[4:0]);
    if (op[10]) r = r | sa;
    if (op[11]) r = r | b;
    return r;
  endfunction

  logic        es_valid_q;
  logic        es_ready_go;
  logic        div_done;
  logic [31:0] fsrc1, fsrc2, alu_res, div_res, es_result;

  assign fsrc1   = fwd_pick(raddr1, src1, fwd_we, fwd_waddr, fwd_wdata);
  assign fsrc2   = fwd_pick(raddr2, src2, fwd_we, fwd_waddr, fwd_wdata);
  assign alu_res = alu_calc(alu_op, fsrc1, fsrc2);

`ifdef EXE_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q, dvd_raw_q;
  logic        qneg_q, rneg_q, mod_q, div0_q;
  logic        div_signed, div_mod, sgn1, sgn2, div_start;
  logic [32:0] sh, diff;
  logic [31:0] q_fin, r_fin;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (es_valid_q && (|div_op) && !flush) state_d = BUSY;
      BUSY:    if (flush) state_d = IDLE;
               else if (cnt_q == 6'd1) state_d = DONE;
      DONE:    if (flush || (es_to_ms_valid && ms_allow_in)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    es_busy  = (state_q == BUSY);
    div_done = (state_q == DONE);
  end

  assign div_signed = div_op[0] | div_op[1];
  assign div_mod    = div_op[1] | div_op[3];
  assign sgn1       = div_signed & fsrc1[31];
  assign sgn2       = div_signed & fsrc2[31];
  assign div_start  = (state_q == IDLE) && (state_d == BUSY);

  // Restoring step: shift one dividend bit into the partial remainder and try a subtract.
  assign sh   = {rem_q, quo_q[31]};
  assign diff = sh - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (reset)                cnt_q <= '0;
    else if (div_start)       cnt_q <= 6'd32;
    else if (state_q == BUSY) cnt_q <= cnt_q - 6'd1;
  end

  always_ff @(posedge clk) begin
    if (div_start) begin
      rem_q     <= '0;
      quo_q     <= sgn1 ? (32'd0 - fsrc1) : fsrc1;
      dvs_q     <= sgn2 ? (32'd0 - fsrc2) : fsrc2;
      dvd_raw_q <= fsrc1;
      qneg_q    <= sgn1 ^ sgn2;
      rneg_q    <= sgn1;
      mod_q     <= div_mod;
      div0_q    <= (fsrc2 == 32'd0);
    end else if (state_q == BUSY) begin
      rem_q <= diff[32] ? sh[31:0] : diff[31:0];
      quo_q <= {quo_q[30:0], ~diff[32]};
    end
  end

  assign q_fin   = qneg_q ? (32'd0 - quo_q) : quo_q;
  assign r_fin   = rneg_q ? (32'd0 - rem_q) : rem_q;
  assign div_res = div0_q ? (mod_q ? dvd_raw_q : 32'hFFFFFFFF) : (mod_q ? r_fin : q_fin);

  assign es_ready_go = !stall && ((div_op == 4'd0) || div_done);
`else
  assign es_busy     = 1'b0;
  assign div_done    = 1'b0;
  assign div_res     = 32'd0;
  assign es_ready_go = !stall;
`endif

  assign es_result      = (|div_op) ? div_res : alu_res;
  assign es_allow_in    = !es_valid_q || (es_ready_go && ms_allow_in);
  assign es_to_ms_valid = es_valid_q && es_ready_go && !flush;
  assign es_rf_waddr_o  = rf_waddr;

  always_ff @(posedge clk) begin
    if (reset)            es_valid_q <= 1'b0;
    else if (flush)       es_valid_q <= 1'b0;
    else if (es_allow_in) es_valid_q <= ds_to_es_valid;
  end

  // EXE -> MEM boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      ms_pc       <= RESET_PC;
      ms_addr     <= '0;
      ms_wdata    <= '0;
      ms_rf_wdata <= '0;
      ms_mem_en   <= 1'b0;
      ms_mem_we   <= '0;
      ms_rf_we    <= '0;
      ms_rf_waddr <= '0;
    end else if (ms_allow_in) begin
      ms_valid    <= es_to_ms_valid;
      ms_pc       <= ds_pc;
      ms_addr     <= alu_res;
      ms_wdata    <= fsrc2;
      ms_rf_wdata <= es_result;
      ms_mem_en   <= mem_en;
      ms_mem_we   <= mem_we;
      ms_rf_we    <= rf_we;
      ms_rf_waddr <= rf_waddr;
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed, table-driven bench for exe_stage_mc (ALU, forwarding, divider corners, flush, hold, reset).
module tb_exe_stage_mc;

`ifdef EXE_DIV_EN
  localparam bit DIV_BUILD = 1'b1;
  localparam int DIV_LAT   = 35;
`else
  localparam bit DIV_BUILD = 1'b0;
  localparam int DIV_LAT   = 2;
`endif
  localparam int NV = 20;

  logic        clk, reset, ds_to_es_valid, es_allow_in, flush, stall;
  logic [31:0] ds_pc, src1, src2;
  logic [11:0] alu_op;
  logic [3:0]  div_op, mem_we, rf_we;
  logic [4:0]  raddr1, raddr2, rf_waddr;
  logic        mem_en, ms_allow_in;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic        es_to_ms_valid, es_busy, ms_valid, ms_mem_en;
  logic [4:0]  es_rf_waddr_o, ms_rf_waddr;
  logic [31:0] ms_pc, ms_addr, ms_wdata, ms_rf_wdata;
  logic [3:0]  ms_mem_we, ms_rf_we;

  exe_stage_mc #(.NUM_FWD(2), .RESET_PC(32'h1bfffffc)) dut (
    .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .es_allow_in(es_allow_in),
    .flush(flush), .stall(stall), .ds_pc(ds_pc), .alu_op(alu_op), .div_op(div_op),
    .src1(src1), .src2(src2), .raddr1(raddr1), .raddr2(raddr2), .mem_en(mem_en),
    .mem_we(mem_we), .rf_we(rf_we), .rf_waddr(rf_waddr), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .ms_allow_in(ms_allow_in),
    .es_to_ms_valid(es_to_ms_valid), .es_rf_waddr_o(es_rf_waddr_o), .es_busy(es_busy),
    .ms_valid(ms_valid), .ms_pc(ms_pc), .ms_addr(ms_addr), .ms_wdata(ms_wdata),
    .ms_rf_wdata(ms_rf_wdata), .ms_mem_en(ms_mem_en), .ms_mem_we(ms_mem_we),
    .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr)
  );

  typedef struct {
    logic [11:0] alu_op;
    logic [3:0]  div_op;
    logic [31:0] s1, s2;
    logic [4:0]  r1, r2;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [31:0] exp_rf, exp_wd;
  } vec_t;

  vec_t vecs[NV];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [11:0] a, input logic [3:0] d, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [1:0] we, input logic [9:0] wa, input logic [63:0] wd,
                              input logic [31:0] er, input logic [31:0] ew);
    vec_t v;
    v.alu_op = a; v.div_op = d; v.s1 = s1; v.s2 = s2; v.r1 = r1; v.r2 = r2;
    v.we = we; v.wa = wa; v.wd = wd; v.exp_rf = er; v.exp_wd = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic issue(input vec_t v, input logic [31:0] pc, input logic [4:0] wa);
    alu_op = v.alu_op; div_op = v.div_op; src1 = v.s1; src2 = v.s2;
    raddr1 = v.r1; raddr2 = v.r2; fwd_we = v.we; fwd_waddr = v.wa; fwd_wdata = v.wd;
    ds_pc = pc; rf_waddr = wa; rf_we = 4'hf; mem_en = 1'b0; mem_we = 4'h0;
    ds_to_es_valid = 1'b1;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    bit          isdiv, allow_bad;
    int          lat;
    logic [31:0] exp_rf, pc;
    v = vecs[i];
    isdiv = (v.div_op != 4'd0);
    allow_bad = 1'b0;
    pc = 32'h1c000000 + 32'(i * 4);
    issue(v, pc, 5'(i + 1));
    chk($sformatf("vec%0d es_rf_waddr_o", i), 32'(es_rf_waddr_o), 32'(i + 1));
    lat = 1;
    while (ms_valid !== 1'b1 && lat < 60) begin
      if (es_allow_in !== 1'b0 && lat <= 33) allow_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
      if (lat == 2) fwd_we = 2'b00;
    end
    chk($sformatf("vec%0d latency", i), 32'(lat), 32'(isdiv ? DIV_LAT : 2));
    exp_rf = (isdiv && !DIV_BUILD) ? 32'd0 : v.exp_rf;
    chk($sformatf("vec%0d ms_rf_wdata", i), ms_rf_wdata, exp_rf);
    chk($sformatf("vec%0d ms_pc", i), ms_pc, pc);
    if (!isdiv) begin
      chk($sformatf("vec%0d ms_addr", i), ms_addr, v.exp_rf);
      chk($sformatf("vec%0d ms_wdata", i), ms_wdata, v.exp_wd);
    end
`ifdef EXE_DIV_EN
    if (isdiv) chk($sformatf("vec%0d allow_in low while dividing", i), 32'(allow_bad), 32'd0);
`endif
    @(posedge clk); #1;
    chk($sformatf("vec%0d single handoff", i), 32'(ms_valid), 32'd0);
  endtask

  initial begin
    int handoffs;
    vecs[0]  = mk(12'h001, 4'h0, 32'd5, 32'd7, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0, 32'd12, 32'd7);
    vecs[1]  = mk(12'h001, 4'h0, 32'h100, 32'd0, 5'd3, 5'd0, 2'b11, {5'd3, 5'd3},
                  {32'hB, 32'hA}, 32'hA, 32'd0);
    vecs[2]  = mk(12'h001, 4'h0, 32'h100, 32'd1, 5'd3, 5'd0, 2'b10, {5'd3, 5'd3},
                  {32'hB, 32'hA}, 32'hC, 32'd1);
    vecs[3]  = mk(12'h001, 4'h0, 32'd5, 32'd1, 5'd0, 5'd4, 2'b11, {5'd0, 5'd0},
                  {32'h77, 32'h66}, 32'd6, 32'd1);
    vecs[4]  = mk(12'h002, 4'h0, 32'h30, 32'h99, 5'd6, 5'd5, 2'b01, {5'd0, 5'd5},
                  {32'd0, 32'h20}, 32'h10, 32'h20);
    vecs[5]  = mk(12'h008, 4'h0, 32'd1, 32'hFFFFFFFF, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0, 32'd1, 32'hFFFFFFFF);
    vecs[6]  = mk(12'h004, 4'h0, 32'hFFFFFFFF, 32'd1, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0, 32'd1, 32'd1);
    vecs[7]  = mk(12'h400, 4'h0, 32'h80000000, 32'd4, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0, 32'hF8000000, 32'd4);
    vecs[8]  = mk(12'h100, 4'h0, 32'd1, 32'd31, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0, 32'h80000000, 32'd31);
    vecs[9]  = mk(12'h080, 4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0,
                  32'h0FF00FF0, 32'hFF00FF00);
    vecs[10] = mk(12'h020, 4'h0, 32'd0, 32'h0000FFFF, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0,
                  32'hFFFF0000, 32'h0000FFFF);
    vecs[11] = mk(12'h800, 4'h0, 32'd0, 32'h12345000, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0,
                  32'h12345000, 32'h12345000);
    vecs[12] = mk(12'h000, 4'h1, 32'hFFFFFFF9, 32'd2, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0, 32'hFFFFFFFD, 32'd0);
    vecs[13] = mk(12'h000, 4'h2, 32'hFFFFFFF9, 32'd2, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0, 32'hFFFFFFFF, 32'd0);
    vecs[14] = mk(12'h000, 4'h4, 32'd9, 32'd0, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0, 32'hFFFFFFFF, 32'd0);
    vecs[15] = mk(12'h000, 4'h8, 32'd9, 32'd0, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0, 32'd9, 32'd0);
    vecs[16] = mk(12'h000, 4'h1, 32'h80000000, 32'hFFFFFFFF, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0,
                  32'h80000000, 32'd0);
    vecs[17] = mk(12'h000, 4'h4, 32'd0, 32'd7, 5'd7, 5'd2, 2'b01, {5'd0, 5'd7},
                  {32'd0, 32'd100}, 32'd14, 32'd0);
    vecs[18] = mk(12'h000, 4'h8, 32'd0, 32'd7, 5'd7, 5'd2, 2'b01, {5'd0, 5'd7},
                  {32'd0, 32'd100}, 32'd2, 32'd0);
    vecs[19] = mk(12'h000, 4'h2, 32'd7, 32'hFFFFFFFE, 5'd1, 5'd2, 2'b00, 10'd0, 64'd0, 32'd1, 32'd0);

    reset = 1'b1; ds_to_es_valid = 1'b0; flush = 1'b0; stall = 1'b0; ms_allow_in = 1'b1;
    ds_pc = '0; alu_op = '0; div_op = '0; src1 = '0; src2 = '0; raddr1 = '0; raddr2 = '0;
    mem_en = 1'b0; mem_we = '0; rf_we = '0; rf_waddr = '0; fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ms_valid", 32'(ms_valid), 32'd0);
    chk("reset ms_pc", ms_pc, 32'h1bfffffc);
    chk("reset ms_rf_wdata", ms_rf_wdata, 32'd0);
    chk("reset es_allow_in", 32'(es_allow_in), 32'd1);
    chk("reset es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    chk("reset es_busy", 32'(es_busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Flush in BUSY cycle 10 (or the single EXE cycle when no divider is built).
    issue(vecs[12], 32'h1c001000, 5'd9);
`ifdef EXE_DIV_EN
    repeat (10) @(posedge clk);
    #1;
    chk("flush es_busy before", 32'(es_busy), 32'd1);
`endif
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush es_busy after", 32'(es_busy), 32'd0);
    chk("flush es_allow_in after", 32'(es_allow_in), 32'd1);
    handoffs = 0;
    for (int c = 0; c < 40; c++) begin
      if (ms_valid === 1'b1) handoffs++;
      @(posedge clk); #1;
    end
    chk("flush no handoff", 32'(handoffs), 32'd0);
    run_vec(0);

    // MEM back-pressure while the result is ready.
    ms_allow_in = 1'b0;
    issue(vecs[13], 32'h1c002000, 5'd10);
`ifdef EXE_DIV_EN
    repeat (33) @(posedge clk);
    #1;
`endif
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hold%0d ms_valid", c), 32'(ms_valid), 32'd0);
      chk($sformatf("hold%0d es_allow_in", c), 32'(es_allow_in), 32'd0);
      chk($sformatf("hold%0d es_to_ms_valid", c), 32'(es_to_ms_valid), 32'd1);
      @(posedge clk); #1;
    end
    ms_allow_in = 1'b1;
    @(posedge clk); #1;
    chk("hold release ms_valid", 32'(ms_valid), 32'd1);
    chk("hold release ms_rf_wdata", ms_rf_wdata, DIV_BUILD ? 32'hFFFFFFFF : 32'd0);
    chk("hold release ms_pc", ms_pc, 32'h1c002000);
    @(posedge clk); #1;
    chk("hold single handoff", 32'(ms_valid), 32'd0);

    // Reset in the middle of a divide.
    issue(vecs[12], 32'h1c003000, 5'd11);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset ms_valid", 32'(ms_valid), 32'd0);
    chk("midreset ms_pc", ms_pc, 32'h1bfffffc);
    chk("midreset ms_rf_wdata", ms_rf_wdata, 32'd0);
    chk("midreset ms_rf_waddr", 32'(ms_rf_waddr), 32'd0);
    chk("midreset ms_rf_we", 32'(ms_rf_we), 32'd0);
    chk("midreset es_busy", 32'(es_busy), 32'd0);
    chk("midreset es_allow_in", 32'(es_allow_in), 32'd1);
    chk("midreset es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
